// File: rtl/elevator_car_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : elevator_car_ctrl_if
// Purpose  : Bundle between the elevator car-motion controller and the
//            surrounding logic (call buttons, time base, display stage).
// Signals  : tick       - one-cycle slow timing enable
//            req[7:0]   - floor-call buttons, bit i = floor i
//            door_hold  - hold door open (only with ELEV_DOOR_HOLD_EN)
//            floor      - current car floor 0..7
//            countdown  - ticks left in the current MOVE/DOOR interval
//            status     - one-hot IDLE/UP/DOWN/DOOR
//            floor_btn  - pending-call lamps
// Modports : master - drives tick/req, observes car state
//            slave  - the controller
// Revision : 1.0 - initial release
// ============================================================================
interface elevator_car_ctrl_if;
   logic       tick;
   logic [7:0] req;
`ifdef ELEV_DOOR_HOLD_EN
   logic       door_hold;
`endif
   logic [2:0] floor;
   logic [2:0] countdown;
   logic [3:0] status;
   logic [7:0] floor_btn;

   modport master (
      output tick,
      output req,
`ifdef ELEV_DOOR_HOLD_EN
      output door_hold,
`endif
      input  floor,
      input  countdown,
      input  status,
      input  floor_btn
   );

   modport slave (
      input  tick,
      input  req,
`ifdef ELEV_DOOR_HOLD_EN
      input  door_hold,
`endif
      output floor,
      output countdown,
      output status,
      output floor_btn
   );
endinterface : elevator_car_ctrl_if
`default_nettype wire

// File: rtl/elevator_car_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : elevator_car_ctrl
// Purpose  : Car-motion controller for an 8-floor elevator. Latches floor
//            calls, runs a SCAN (collective) up/down policy, and times travel
//            and door intervals from a slow tick enable.
// Ports    : clk    - system clock
//            rst_n  - asynchronous active-low reset
//            bus    - elevator_car_ctrl_if.slave (tick, req, [door_hold],
//                     floor, countdown, status, floor_btn)
// Params   : TRAVEL_TICKS - ticks to travel one floor (1..7)
//            DOOR_TICKS   - ticks the door stays open (1..7)
// Options  : ELEV_DOOR_HOLD_EN - adds door_hold, which freezes the door
//            countdown while asserted in DOOR.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_car_ctrl #(
   parameter int TRAVEL_TICKS = 3,
   parameter int DOOR_TICKS   = 4
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   elevator_car_ctrl_if.slave bus
);

   if (TRAVEL_TICKS < 1 || TRAVEL_TICKS > 7) begin : g_bad_travel_ticks
      $error("elevator_car_ctrl: TRAVEL_TICKS must be in 1..7");
   end
   if (DOOR_TICKS < 1 || DOOR_TICKS > 7) begin : g_bad_door_ticks
      $error("elevator_car_ctrl: DOOR_TICKS must be in 1..7");
   end

   // State encoding doubles as the one-hot status output.
   localparam logic [3:0] c_idle = 4'b0001;
   localparam logic [3:0] c_up   = 4'b0010;
   localparam logic [3:0] c_down = 4'b0100;
   localparam logic [3:0] c_door = 4'b1000;

   localparam logic [2:0] c_travel = 3'(TRAVEL_TICKS);
   localparam logic [2:0] c_door_t = 3'(DOOR_TICKS);

   // Bits strictly above / strictly below floor f.
   function automatic logic [7:0] above_mask(input logic [2:0] f);
      return 8'hFE << f;
   endfunction

   function automatic logic [7:0] below_mask(input logic [2:0] f);
      return ~(8'hFF << f);
   endfunction

   logic [3:0] r_state;
   logic [2:0] r_floor;
   logic [2:0] r_cnt;
   logic [7:0] r_pend;
   logic       r_dir_up;

   logic [3:0] w_state_nxt;
   logic [2:0] w_floor_nxt;
   logic [2:0] w_cnt_nxt;
   logic [7:0] w_pend_nxt;
   logic       w_dir_up_nxt;

   logic [7:0] w_floor_oh;
   logic [7:0] w_req_eff;
   logic [7:0] w_np;
   logic       w_here;
   logic       w_above;
   logic       w_below;
   logic [2:0] w_arr_floor;
   logic       w_arr_here;
   logic       w_arr_beyond;
   logic       w_hold;

`ifdef ELEV_DOOR_HOLD_EN
   assign w_hold = bus.door_hold;
`else
   assign w_hold = 1'b0;
`endif

   assign w_floor_oh = 8'b1 << r_floor;

   // A call for the floor whose door is open re-opens the door instead of
   // being latched as a pending request.
   assign w_req_eff  = (r_state == c_door) ? (bus.req & ~w_floor_oh) : bus.req;
   assign w_np       = r_pend | w_req_eff;

   assign w_here     = w_np[r_floor];
   assign w_above    = |(w_np & above_mask(r_floor));
   assign w_below    = |(w_np & below_mask(r_floor));

   // Floor reached on the arrival tick; only meaningful in UP/DOWN, where the
   // SCAN policy guarantees the car is never at the end it is moving toward.
   assign w_arr_floor  = (r_state == c_up) ? (r_floor + 3'd1) : (r_floor - 3'd1);
   assign w_arr_here   = w_np[w_arr_floor];
   assign w_arr_beyond = (r_state == c_up) ? |(w_np & above_mask(w_arr_floor))
                                           : |(w_np & below_mask(w_arr_floor));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= c_idle;
         r_floor  <= 3'd0;
         r_cnt    <= 3'd0;
         r_pend   <= 8'h00;
         r_dir_up <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_floor  <= w_floor_nxt;
         r_cnt    <= w_cnt_nxt;
         r_pend   <= w_pend_nxt;
         r_dir_up <= w_dir_up_nxt;
      end
   end

   // Next-state and datapath decisions
   always_comb begin
      w_state_nxt  = r_state;
      w_floor_nxt  = r_floor;
      w_cnt_nxt    = r_cnt;
      w_pend_nxt   = w_np;
      w_dir_up_nxt = r_dir_up;

      case (r_state)
         c_idle: begin
            if (w_here) begin
               w_state_nxt = c_door;
               w_cnt_nxt   = c_door_t;
               w_pend_nxt  = w_np & ~w_floor_oh;
            end else if (w_above && (r_dir_up || !w_below)) begin
               w_state_nxt  = c_up;
               w_dir_up_nxt = 1'b1;
               w_cnt_nxt    = c_travel;
            end else if (w_below) begin
               w_state_nxt  = c_down;
               w_dir_up_nxt = 1'b0;
               w_cnt_nxt    = c_travel;
            end
         end

         c_up, c_down: begin
            if (bus.tick) begin
               if (r_cnt > 3'd1) begin
                  w_cnt_nxt = r_cnt - 3'd1;
               end else begin
                  w_floor_nxt = w_arr_floor;
                  if (w_arr_here) begin
                     w_state_nxt = c_door;
                     w_cnt_nxt   = c_door_t;
                     w_pend_nxt  = w_np & ~(8'b1 << w_arr_floor);
                  end else if (w_arr_beyond) begin
                     w_cnt_nxt   = c_travel;
                  end else begin
                     w_state_nxt = c_idle;
                     w_cnt_nxt   = 3'd0;
                  end
               end
            end
         end

         c_door: begin
            // Re-open takes priority over the expiring tick.
            if (bus.req[r_floor]) begin
               w_cnt_nxt = c_door_t;
            end else if (bus.tick && !w_hold) begin
               if (r_cnt > 3'd1) begin
                  w_cnt_nxt = r_cnt - 3'd1;
               end else begin
                  w_state_nxt = c_idle;
                  w_cnt_nxt   = 3'd0;
               end
            end
         end

         default: begin
            w_state_nxt = c_idle;
            w_cnt_nxt   = 3'd0;
         end
      endcase
   end

   // Outputs come straight from registers
   always_comb begin
      bus.floor     = r_floor;
      bus.countdown = r_cnt;
      bus.status    = r_state;
      bus.floor_btn = r_pend;
   end

endmodule : elevator_car_ctrl
`default_nettype wire
